stopwatch_sequencer: RTL

//  Control FSM for the lab3b stopwatch datapath. Turns the pause/sel/adj inputs and
//  the tick strobes from the clock divider into one-cycle increment/clear strobes
//  for the seconds and minutes counters, plus field-blink enables for the display mux.

---
 rtl/stopwatch_sequencer.sv | 132 +++++++++++++
 1 files changed

// File: rtl/stopwatch_sequencer.sv
// stopwatch_sequencer
// Control FSM for the lab3b stopwatch. It turns the debounced pause/sel/adj levels
// and the divider tick strobes into one-cycle increment/clear strobes for the
// seconds and minutes counters, and into field-blink enables for the display mux.
// Optional build macro: SW_INPUT_SYNC_EN routes pause/sel/adj through 2-flop
// synchronizers before use, adding two cycles of input latency.
module stopwatch_sequencer #(
   parameter int MODE_W = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              pause,
   input  logic              sel,
   input  logic              adj,
   input  logic              tick_1hz,
   input  logic              tick_2hz,
   input  logic              tick_blink,
   input  logic              sec_at_max,
   output logic              sec_inc,
   output logic              min_inc,
   output logic              cnt_clr,
   output logic              blink_sec,
   output logic              blink_min,
   output logic [MODE_W-1:0] mode
);

   typedef enum logic [MODE_W-1:0] {
      RUN     = MODE_W'(1),
      PAUSED  = MODE_W'(2),
      ADJ_SEC = MODE_W'(4),
      ADJ_MIN = MODE_W'(8)
   } state_t;

   state_t state;
   state_t next_state;
   logic   paused;
   logic   next_paused;
   logic   pause_prev;
   logic   pause_edge;
   logic   phase;
   logic   next_phase;
   logic   pause_use;
   logic   sel_use;
   logic   adj_use;

`ifdef SW_INPUT_SYNC_EN
   logic [1:0] pause_sync;
   logic [1:0] sel_sync;
   logic [1:0] adj_sync;

   // Two-flop synchronizers so asynchronous button levels settle before the FSM sees them
   always_ff @(posedge clk) begin
      if (reset) begin
         pause_sync <= 2'b00;
         sel_sync   <= 2'b00;
         adj_sync   <= 2'b00;
      end else begin
         pause_sync <= {pause_sync[0], pause};
         sel_sync   <= {sel_sync[0], sel};
         adj_sync   <= {adj_sync[0], adj};
      end
   end

   assign pause_use = pause_sync[1];
   assign sel_use   = sel_sync[1];
   assign adj_use   = adj_sync[1];
`else
   assign pause_use = pause;
   assign sel_use   = sel;
   assign adj_use   = adj;
`endif

   // Work out the pause edge, the post-toggle paused flag, the next state and blink phase
   always_comb begin
      pause_edge  = pause_use & ~pause_prev;
      next_paused = paused ^ (pause_edge & ~adj_use);
      next_state  = RUN;
      if (adj_use) begin
         next_state = sel_use ? ADJ_MIN : ADJ_SEC;
      end else if (next_paused) begin
         next_state = PAUSED;
      end
      next_phase = 1'b0;
      if (next_state == ADJ_SEC || next_state == ADJ_MIN) begin
         next_phase = phase ^ tick_blink;
      end
   end

   // State register plus registered strobes; strobes are decided by the state held before the edge
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= RUN;
         paused     <= 1'b0;
         pause_prev <= 1'b0;
         phase      <= 1'b0;
         sec_inc    <= 1'b0;
         min_inc    <= 1'b0;
         cnt_clr    <= 1'b1;
         blink_sec  <= 1'b0;
         blink_min  <= 1'b0;
      end else begin
         state      <= next_state;
         paused     <= next_paused;
         pause_prev <= pause_use;
         phase      <= next_phase;
         cnt_clr    <= 1'b0;
         blink_sec  <= next_phase & (next_state == ADJ_SEC);
         blink_min  <= next_phase & (next_state == ADJ_MIN);
         case (state)
            RUN: begin
               sec_inc <= tick_1hz;
               min_inc <= tick_1hz & sec_at_max;
            end
            ADJ_SEC: begin
               sec_inc <= tick_2hz;
               min_inc <= 1'b0;
            end
            ADJ_MIN: begin
               sec_inc <= 1'b0;
               min_inc <= tick_2hz;
            end
            default: begin
               sec_inc <= 1'b0;
               min_inc <= 1'b0;
            end
         endcase
      end
   end

   assign mode = state;

endmodule
